// File: rtl/sram_host_ctrl.sv
// sram_host_ctrl: host-side initiator for a single-port synchronous SRAM.
// Turns a valid/ready request stream into SRAM control cycles. All SRAM pins
// and the DATA drive enable come straight from flops.
// Optional build macro: SRAM_HOST_CTRL_VERIFY_EN. When it is defined, each
// write is followed by a verify read of the same address. A mismatch sets the
// sticky verify_err output.
module sram_host_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SRAM_HOST_CTRL_VERIFY_EN
    output logic                  verify_err,
`endif
    output logic [ADDR_WIDTH-1:0] ADDR,
    inout  wire  [DATA_WIDTH-1:0] DATA,
    output logic                  CSb,
    output logic                  WEb,
    output logic                  OEb
);

    typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_WAIT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_en;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
    logic                  verify_q;
`endif

    // Gate req_ready with rstb so that no request is accepted while reset is held.
    assign req_ready = rstb && (state == IDLE);

    // The host drives DATA only while drive_en is set. drive_en moves in
    // lock-step with WEb, so the host never drives DATA while OEb is low.
    assign DATA = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

    // Request FSM. It also produces the registered SRAM pins and the response.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ADDR      <= '0;
            CSb       <= 1'b1;
            WEb       <= 1'b1;
            OEb       <= 1'b1;
            drive_en  <= 1'b0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
            verify_q   <= 1'b0;
            verify_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ADDR    <= req_addr;
                        wdata_q <= req_wdata;
                        CSb     <= 1'b0;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
                        verify_q <= 1'b0;
`endif
                        if (req_we) begin
                            WEb      <= 1'b0;
                            OEb      <= 1'b1;
                            drive_en <= 1'b1;
                            state    <= WR;
                        end else begin
                            WEb      <= 1'b1;
                            OEb      <= 1'b0;
                            drive_en <= 1'b0;
                            state    <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    // The SRAM captures the write on this edge. Release the bus here.
                    WEb      <= 1'b1;
                    drive_en <= 1'b0;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
                    // Keep CSb low and read the same word back.
                    OEb      <= 1'b0;
                    verify_q <= 1'b1;
                    state    <= RD_ISSUE;
`else
                    CSb      <= 1'b1;
                    state    <= IDLE;
`endif
                end
                RD_ISSUE: begin
                    // The SRAM launches the data on this edge. Hold all pins steady.
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    CSb   <= 1'b1;
                    OEb   <= 1'b1;
                    state <= IDLE;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
                    if (verify_q) begin
                        if (DATA != wdata_q) verify_err <= 1'b1;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= DATA;
                    end
`else
                    rsp_valid <= 1'b1;
                    rsp_rdata <= DATA;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// tb_sram_host_ctrl: directed self-checking bench for sram_host_ctrl.
// It contains a behavioural synchronous SRAM model with a registered read
// port. Define SRAM_HOST_CTRL_VERIFY_EN to build and exercise the write-verify
// variant.
module tb_sram_host_ctrl;

`ifdef SRAM_HOST_CTRL_VERIFY_EN
    localparam int WR_CYC = 4;
`else
    localparam int WR_CYC = 2;
`endif

    logic       clk = 1'b0;
    logic       rstb;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_valid;
    logic [1:0] rsp_rdata;
    logic [3:0] ADDR;
    wire  [1:0] DATA;
    logic       CSb;
    logic       WEb;
    logic       OEb;
`ifdef SRAM_HOST_CTRL_VERIFY_EN
    logic       verify_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    int wr_edges = 0;
    int rsp_cnt  = 0;
    int viol_cnt = 0;
    logic [1:0] exp_q[$];
    logic [1:0] shadow [16];

    // SRAM model state.
    logic [1:0] mem [16];
    logic [1:0] dout;
    logic       corrupt = 1'b0;

    sram_host_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef SRAM_HOST_CTRL_VERIFY_EN
        .verify_err(verify_err),
`endif
        .ADDR      (ADDR),
        .DATA      (DATA),
        .CSb       (CSb),
        .WEb       (WEb),
        .OEb       (OEb)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous write and registered read. When corrupt is set,
    // the read path returns a wrong word for address 3.
    always @(posedge clk) begin
        if (!CSb) begin
            if (!WEb) mem[ADDR] <= DATA;
            else      dout <= (corrupt && ADDR == 4'd3) ? 2'b11 : mem[ADDR];
        end
    end
    assign DATA = !OEb ? dout : 2'bzz;

    // Count cycles, write strobes seen by the SRAM, and bus contention events.
    always @(posedge clk) begin
        cyc_cnt++;
        if (rstb && !CSb && !WEb) wr_edges++;
    end

    // Check every response against the expected queue, and count contention.
    always @(negedge clk) begin
        if (!WEb && !OEb) viol_cnt++;
        if (rstb && rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else check("rsp_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for a handshake on the current request. Returns #1 after the accepting edge.
    task automatic wait_accept();
        int n = 0;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        check("idle_timeout", 32'(req_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Stream 16 requests with req_valid held high. Returns the number of cycles
    // between the first and the last acceptance.
    task automatic stream16(input logic we, output int span);
        int first_c = 0;
        span = 0;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_we    = we;
            req_addr  = 4'(i);
            req_wdata = 2'(i);
            if (!we) exp_q.push_back(shadow[i]);
            wait_accept();
            if (we) shadow[i] = 2'(i);
            if (i == 0) first_c = cyc_cnt;
            span = cyc_cnt - first_c;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        int span;
        int r0;
        int w0;
        rstb      = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 4'd9;
        req_wdata = 2'b11;

        // Reset state with a request pending.
        repeat (3) @(posedge clk);
        #1;
        check("rst_csb", 32'(CSb), 1);
        check("rst_web", 32'(WEb), 1);
        check("rst_oeb", 32'(OEb), 1);
        check("rst_addr", 32'(ADDR), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_ready", 32'(req_ready), 0);
        req_valid = 1'b0;
        rstb      = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 1);
        @(posedge clk);
        #1;

        // Directed write of 2'b10 to address 5.
        w0 = wr_edges;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd5; req_wdata = 2'b10;
        wait_accept();
        req_valid = 1'b0;
        check("wr_csb", 32'(CSb), 0);
        check("wr_web", 32'(WEb), 0);
        check("wr_oeb", 32'(OEb), 1);
        check("wr_addr", 32'(ADDR), 5);
        check("wr_busy", 32'(req_ready), 0);
`ifndef SRAM_HOST_CTRL_VERIFY_EN
        @(posedge clk);
        #1;
        check("wr_done_csb", 32'(CSb), 1);
        check("wr_done_web", 32'(WEb), 1);
        check("wr_done_ready", 32'(req_ready), 1);
`endif
        wait_idle();
        check("wr_edges", wr_edges - w0, 1);
        check("mem5", 32'(mem[5]), 2);
        shadow[5] = 2'b10;

        // Directed read of address 5: two-cycle latency, single-cycle strobe.
        r0 = rsp_cnt;
        exp_q.push_back(2'b10);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd5;
        wait_accept();
        req_valid = 1'b0;
        check("rd_csb", 32'(CSb), 0);
        check("rd_oeb", 32'(OEb), 0);
        check("rd_web", 32'(WEb), 1);
        check("rd_busy0", 32'(req_ready), 0);
        check("rd_valid0", 32'(rsp_valid), 0);
        @(posedge clk);
        #1;
        check("rd_valid1", 32'(rsp_valid), 0);
        check("rd_busy1", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check("rd_valid2", 32'(rsp_valid), 1);
        check("rd_rdata2", 32'(rsp_rdata), 2);
        check("rd_ready2", 32'(req_ready), 1);
        check("rd_csb2", 32'(CSb), 1);
        check("rd_oeb2", 32'(OEb), 1);
        @(posedge clk);
        #1;
        check("rd_valid3", 32'(rsp_valid), 0);
        check("rd_hold3", 32'(rsp_rdata), 2);
        check("rd_count", rsp_cnt - r0, 1);

        // Fill all addresses, then read everything back with req_valid held high.
        stream16(1'b1, span);
        check("wr_span", span, 15 * WR_CYC);
        wait_idle();
        r0 = rsp_cnt;
        stream16(1'b0, span);
        check("rd_span", span, 45);
        drain();
        check("rd_stream_count", rsp_cnt - r0, 16);

        // Random read/write mix checked against the shadow copy.
        for (int i = 0; i < 40; i++) begin
            req_valid = 1'b1;
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 15));
            req_wdata = 2'($urandom_range(0, 3));
            if (!req_we) exp_q.push_back(shadow[req_addr]);
            wait_accept();
            if (req_we) shadow[req_addr] = req_wdata;
        end
        req_valid = 1'b0;
        drain();
        check("contention", viol_cnt, 0);

        // Reset in the middle of a read (RD_ISSUE): the read is aborted with no response.
        r0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
        wait_accept();
        req_valid = 1'b0;
        rstb = 1'b0;
        #1;
        check("abort_csb", 32'(CSb), 1);
        check("abort_oeb", 32'(OEb), 1);
        check("abort_web", 32'(WEb), 1);
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_cnt - r0, 0);
        exp_q.push_back(shadow[7]);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd7;
        wait_accept();
        req_valid = 1'b0;
        drain();
        check("abort_next_rd", rsp_cnt - r0, 1);

`ifdef SRAM_HOST_CTRL_VERIFY_EN
        // A clean verify leaves verify_err low and produces no response.
        r0 = rsp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd3; req_wdata = 2'b01;
        wait_accept();
        req_valid = 1'b0;
        wait_idle();
        check("verify_ok", 32'(verify_err), 0);
        check("verify_no_rsp", rsp_cnt - r0, 0);
        // A corrupted read-back sets verify_err, which stays set.
        corrupt = 1'b1;
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
        wait_idle();
        corrupt = 1'b0;
        check("verify_err_set", 32'(verify_err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("verify_err_sticky", 32'(verify_err), 1);
        check("verify_no_rsp2", rsp_cnt - r0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_host_ctrl.md
Name: sram_host_ctrl

Overview:
Host-side initiator for the single-port synchronous SRAM macro interface (DATA inout, ADDR, CSb, WEb, OEb, clk). It converts a valid/ready request stream (read or write) into correctly sequenced SRAM control cycles and returns read data on a one-cycle response strobe. It sits between BIST/characterisation logic or a system bus and the generated SRAM, and is the only driver of the shared DATA bus on the host side.

Parameters:
DATA_WIDTH, 2, SRAM word width in bits
ADDR_WIDTH, 4, SRAM address width; depth = 1<<ADDR_WIDTH

Ports:
clk  input  1  clock; same clock as the SRAM
rstb  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle strobe: rsp_rdata valid
rsp_rdata  output  DATA_WIDTH  read data
ADDR  output  ADDR_WIDTH  SRAM address
DATA  inout  DATA_WIDTH  SRAM bidirectional data
CSb  output  1  SRAM chip select, active low
WEb  output  1  SRAM write enable, active low
OEb  output  1  SRAM output enable, active low

Behaviour:
- All SRAM-side outputs and the DATA drive enable are registered; no combinational path from req_* to the SRAM pins.
- Reset (rstb=0, asynchronous): state IDLE, CSb=1, WEb=1, OEb=1, ADDR=0, DATA hi-Z, rsp_valid=0, rsp_rdata=0. req_ready=1 once rstb deasserts.
- States: IDLE, WR, RD_ISSUE, RD_WAIT.
- IDLE: req_ready=1. A handshake at edge N latches addr, we and wdata, and drives ADDR and CSb=0.
  - Write: WEb=0, OEb=1, DATA driven with wdata; go to WR.
  - Read: WEb=1, OEb=0, DATA hi-Z; go to RD_ISSUE.
- WR: req_ready=0. The SRAM captures the write at edge N+1. At N+1 the controller sets CSb=1, WEb=1, releases DATA and returns to IDLE. A write occupies 2 cycles.
- RD_ISSUE: req_ready=0. The SRAM launches data_out at edge N+1. Hold CSb=0, WEb=1, OEb=0 and ADDR; go to RD_WAIT.
- RD_WAIT: req_ready=0. At edge N+2, sample DATA into rsp_rdata, pulse rsp_valid=1 for exactly one cycle, set CSb=1 and OEb=1, and return to IDLE.
  - The repeated read at N+2 is harmless because ADDR is unchanged.
  - Read latency: rsp_valid is high in the cycle after edge N+2, i.e. 2 cycles after acceptance.
- Bus contention rule: DATA is driven only while WEb=0. OEb=0 only while WEb=1. The two are never active together, including across state transitions.
- Maximum throughput: 1 request per 2 cycles (write) or 3 cycles (read). req_ready returns high in IDLE in the same cycle rsp_valid is high, so back-to-back requests incur no bubble beyond IDLE.
- req_* values are ignored unless req_valid && req_ready. Held requests stay pending, unaccepted, while busy.
- rsp_rdata holds its last value between strobes.
- Reset mid-operation: the transaction is aborted immediately and no rsp_valid is produced. The bus returns to its reset state asynchronously, with CSb=1 and DATA hi-Z in the same delta.

Optional Feature:
SRAM_HOST_CTRL_VERIFY_EN
- Defined:
  - Adds output port verify_err (1 bit, reset 0, sticky until reset).
  - After WR, the FSM performs a write-verify read of the same address through RD_ISSUE/RD_WAIT.
  - The sampled DATA is compared against the latched wdata; any mismatch sets verify_err.
  - The verify read does not pulse rsp_valid and does not update rsp_rdata.
  - A write then occupies 4 cycles before req_ready returns.
- Undefined: no verify_err port, and writes take 2 cycles as above.

Test Plan:
- Reset check: rstb low with req_valid=1 -> CSb=1, WEb=1, OEb=1, DATA=z, rsp_valid=0, req_ready=0 held off; after release, req_ready=1.
- Write ADDR=5 data 2'b10, then read ADDR=5 -> SRAM sees CSb=0/WEb=0 for exactly one edge; rsp_valid pulses once, 2 cycles after read acceptance, with rsp_rdata=2'b10.
- Write all 16 addresses with addr[1:0], then read back sequentially with req_valid held high -> req_ready low in all busy states; 16 responses in order with matching data; a write costs 2 cycles, a read 3.
- Contention monitor over random read/write mix -> never (DATA driven by controller && OEb=0), never (CSb=0 && OEb=0 && WEb=0).
- Assert rstb low during RD_ISSUE -> no rsp_valid ever pulses for that read, CSb=1 immediately; the next read after reset returns correct data.
- With SRAM_HOST_CTRL_VERIFY_EN: write ADDR=3 data 2'b01 -> verify_err stays 0, no rsp_valid. Force mem[3]=2'b11 in the SRAM model during the verify read -> verify_err=1 and remains 1 until reset.
